seq_detect_param: RTL and testbench
===================================

# seq_detect_param

Parametrised serial bit-pattern detector for the sequence-detector family. It generalises the fixed three-bit Mealy detector to a runtime-programmable pattern of up to MAX_LEN bits, with selectable overlapping or non-overlapping detection, Mealy or Moore output timing, input qualification, and a saturating match counter. It sits directly on a serial bit stream and feeds status and interrupt logic.

## Interface
- MAX_LEN, 8: maximum pattern length in bits, legal range ≥2.
- OVERLAP, 1: 1 = overlapping detection; 0 = history cleared after each match.
- MEALY, 1: 1 = y is combinational in the cycle of the final bit; 0 = y is registered one cycle later.
- CNT_W, 8: width of the match counter.
- LW: localparam, $clog2(MAX_LEN+1).

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  reset, synchronous, active-low.
- cfg_load  in  1  latch cfg_pattern/cfg_len and clear history/counter.
- cfg_pattern  in  MAX_LEN  pattern; bit [len-1] is received first, bit [0] last.
- cfg_len  in  LW  pattern length.
- i_valid  in  1  qualifies i.
- i  in  1  serial data bit.
- y  out  1  match pulse.
- match_cnt  out  CNT_W  saturating count of matches.
- armed  out  1  high when fill ≥ len-1, i.e. the next valid bit can complete a match.

## Operation
- Internal state:
  - hist[MAX_LEN-1:0]: shift register holding the newest bit in [0].
  - fill[LW-1:0]: number of valid bits held, saturating at MAX_LEN.
  - pat, len: latched configuration.
- Accept: on a clock edge with i_valid=1, hist <= {hist[MAX_LEN-2:0], i} and fill <= min(fill+1, MAX_LEN). With i_valid=0, hist and fill hold.
- Match condition hit (combinational), all three must be true:
  - i_valid=1;
  - fill ≥ len-1;
  - {hist, i} low len bits == pat low len bits.
- Effective length: cfg_len=0 or 1 is stored as-is, and len<2 disables detection (hit is never true). cfg_len>MAX_LEN is clamped to MAX_LEN when loaded.
- Non-overlap (OVERLAP=0): on an edge where hit=1, fill <= 0; the bit is still shifted into hist.
- Overlap (OVERLAP=1): fill advances normally; the trailing bits of one match can begin the next.
- y:
  - MEALY=1: y = hit.
  - MEALY=0: y = hit registered, a one-cycle pulse.
- match_cnt increments by one on each hit edge and saturates at 2^CNT_W-1.
- cfg_load (edge):
  - pat/len <= config inputs; fill <= 0; match_cnt <= 0; the Moore y register <= 0.
  - Any i_valid bit in the same cycle is discarded.
  - The old pattern's hit is suppressed in that cycle, so y=0 in Mealy mode.
- Reset (edge with resetn=0):
  - hist=0, fill=0, match_cnt=0, y register=0.
  - pat=0, len=0, so the block is disabled until the first cfg_load.
  - Reset takes priority over cfg_load and over data.
- Reset values of outputs: y=0, match_cnt=0, armed=0.

## Timing
- Mealy: y is asserted in the same cycle as the final pattern bit; state updates at the following edge.
- Moore: y is asserted in the cycle after the edge that accepted the final bit, for exactly one cycle.
- match_cnt reflects a match one cycle after the final bit, in both modes.
- Back-to-back matches:
  - Overlap mode: the minimum gap is 1 valid bit, e.g. pattern 11 on stream 111 gives hits at bits 2 and 3.
  - Non-overlap mode: the minimum gap is len valid bits.
- Gaps with i_valid=0 do not break a partial match.
- Reset or cfg_load mid-pattern abandons the partial match; a following match needs len fresh valid bits.

## Structure
- Shared package seq_det_pkg holds:
  - the function clamp_len(len, max);
  - a mode enum {MODE_OVERLAP, MODE_NONOVERLAP};
  - a localparam helper for LW.
- Sub-module seq_hist_shreg: a MAX_LEN shift register plus fill counter with enable and clear. Detect, config and counter logic stay in the top module.
- Target size: about 150–250 lines of RTL.

## Test plan
- Pattern 101, len=3, OVERLAP=1, MEALY=1; stream 1,0,1,0,1 with i_valid=1 → y high on bits 3 and 5; match_cnt=2.
- Same stream with OVERLAP=0, then 0,1 appended → y on bit 3 and on bit 7 only; bit 5 gives no hit; match_cnt=2.
- MEALY=0, pattern 1101, len=4; stream 1,1,0,1 with i_valid low for 2 cycles between bits 2 and 3 → one y pulse, the cycle after bit 4 is accepted.
- resetn=0 for one cycle after bits 1,0 of 101, then cfg_load 101/3 and stream 1 → no y; a full 1,0,1 is then required for a hit.
- cfg_len=12 with MAX_LEN=8 → clamped to 8; pattern 0xA5 detected after exactly 8 bits. cfg_len=1 → y never asserts.
- CNT_W=2, pattern 11 overlap, five 1s → hits on bits 2–5; match_cnt = 1, 2, 3, 3 (saturates).

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared definitions for the parametrised sequence detector: detection mode,
// the length-register width helper and the configured-length clamp.
package seq_det_pkg;

   typedef enum logic {
      MODE_OVERLAP    = 1'b0,
      MODE_NONOVERLAP = 1'b1
   } mode_e;

   // Width that can hold every value 0..max_len inclusive.
   function automatic int lw_of(input int max_len);
      return $clog2(max_len + 1);
   endfunction

   function automatic int clamp_len(input int len, input int max);
      return (len > max) ? max : len;
   endfunction

endpackage

// File: rtl/seq_hist_shreg.sv
// Serial history shift register (newest bit in [0]) with a saturating count
// of how many valid bits it holds since the last clear.
module seq_hist_shreg
   import seq_det_pkg::*;
#(
   parameter int MAX_LEN = 8,
   parameter int LW      = lw_of(MAX_LEN)
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               en,
   input  logic               clr,
   input  logic               d,
   output logic [MAX_LEN-1:0] hist,
   output logic [LW-1:0]      fill
);

   localparam logic [LW-1:0] FILL_MAX = LW'(MAX_LEN);

   // clr only forgets the count; the shifted bits stay so that a cleared
   // history can never produce a match until fill has recovered anyway.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         hist <= '0;
         fill <= '0;
      end else begin
         if (en) begin
            hist <= {hist[MAX_LEN-2:0], d};
         end
         if (clr) begin
            fill <= '0;
         end else if (en && (fill != FILL_MAX)) begin
            fill <= fill + 1'b1;
         end
      end
   end

endmodule

// File: rtl/seq_detect_param.sv
// Runtime-programmable serial pattern detector with overlap/non-overlap
// detection, Mealy or Moore match pulse, and a saturating match counter.
module seq_detect_param
   import seq_det_pkg::*;
#(
   parameter int MAX_LEN = 8,
   parameter int OVERLAP = 1,
   parameter int MEALY   = 1,
   parameter int CNT_W   = 8,
   localparam int LW     = lw_of(MAX_LEN)
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               cfg_load,
   input  logic [MAX_LEN-1:0] cfg_pattern,
   input  logic [LW-1:0]      cfg_len,
   input  logic               i_valid,
   input  logic               i,
   output logic               y,
   output logic [CNT_W-1:0]   match_cnt,
   output logic               armed
);

   // Input handshake: i is consumed on every rising edge where i_valid=1 and
   // cfg_load=0; there is no back-pressure, the detector is always ready.

   localparam mode_e            MODE    = (OVERLAP != 0) ? MODE_OVERLAP : MODE_NONOVERLAP;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [MAX_LEN-1:0] pat;
   logic [LW-1:0]      len;
   logic [LW-1:0]      len_d;
   logic [MAX_LEN-1:0] hist;
   logic [LW-1:0]      fill;
   logic [MAX_LEN:0]   window;
   logic [MAX_LEN:0]   mask;
   logic               len_ok;
   logic               fill_ok;
   logic               hit;
   logic               sh_en;
   logic               sh_clr;
   logic               y_q;

   assign len_d = LW'(clamp_len(int'(cfg_len), MAX_LEN));

   always_comb begin
      mask = '0;
      for (int k = 0; k <= MAX_LEN; k++) begin
         if (k < int'(len)) begin
            mask[k] = 1'b1;
         end
      end
   end

   assign window  = {hist, i};
   assign len_ok  = (len >= LW'(2));
   // fill >= len-1 written without the subtraction so len=0 cannot wrap.
   assign fill_ok = (({1'b0, fill} + (LW+1)'(1)) >= {1'b0, len});
   assign hit     = i_valid & ~cfg_load & len_ok & fill_ok &
                    (((window ^ {1'b0, pat}) & mask) == '0);
   assign armed   = len_ok & fill_ok;

   assign sh_en  = i_valid & ~cfg_load;
   assign sh_clr = cfg_load | (hit & (MODE == MODE_NONOVERLAP));

   seq_hist_shreg #(
      .MAX_LEN (MAX_LEN),
      .LW      (LW)
   ) u_hist (
      .clk    (clk),
      .resetn (resetn),
      .en     (sh_en),
      .clr    (sh_clr),
      .d      (i),
      .hist   (hist),
      .fill   (fill)
   );

   always_ff @(posedge clk) begin
      if (!resetn) begin
         pat       <= '0;
         len       <= '0;
         match_cnt <= '0;
         y_q       <= 1'b0;
      end else if (cfg_load) begin
         pat       <= cfg_pattern;
         len       <= len_d;
         match_cnt <= '0;
         y_q       <= 1'b0;
      end else begin
         y_q <= hit;
         if (hit && (match_cnt != CNT_MAX)) begin
            match_cnt <= match_cnt + 1'b1;
         end
      end
   end

   assign y = (MEALY != 0) ? hit : y_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: four mode variants share one stimulus stream and
// are checked every cycle against a queue-based model of the detection rules.
module tb_seq_detect_param;

   localparam int ND = 4;

   logic            clk = 1'b0;
   logic            resetn;
   logic            cfg_load;
   logic [7:0]      cfg_pattern;
   logic [3:0]      cfg_len;
   logic            i_valid;
   logic            i;
   logic [ND-1:0]   y_w;
   logic [ND-1:0]   armed_w;
   logic [7:0]      c0, c1, c2;
   logic [1:0]      c3;
   logic [7:0]      cnt_w[ND];

   int n_tests = 0;
   int n_fail  = 0;

   // per-variant configuration: overlap, mealy, counter saturation value
   int ov  [ND] = '{1, 0, 1, 1};
   int me  [ND] = '{1, 1, 0, 1};
   int cmax[ND] = '{255, 255, 255, 3};

   // reference model state
   bit m_hist[$];
   int m_pat, m_len;
   int m_fill[ND], m_cnt[ND];
   bit m_yreg[ND];

   logic [10*ND-1:0] exp_q[$];

   always #5 clk = ~clk;

   assign cnt_w[0] = c0;
   assign cnt_w[1] = c1;
   assign cnt_w[2] = c2;
   assign cnt_w[3] = {6'b0, c3};

   seq_detect_param #(.MAX_LEN(8), .OVERLAP(1), .MEALY(1), .CNT_W(8)) dut0 (
      .clk(clk), .resetn(resetn), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
      .cfg_len(cfg_len), .i_valid(i_valid), .i(i), .y(y_w[0]), .match_cnt(c0), .armed(armed_w[0]));
   seq_detect_param #(.MAX_LEN(8), .OVERLAP(0), .MEALY(1), .CNT_W(8)) dut1 (
      .clk(clk), .resetn(resetn), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
      .cfg_len(cfg_len), .i_valid(i_valid), .i(i), .y(y_w[1]), .match_cnt(c1), .armed(armed_w[1]));
   seq_detect_param #(.MAX_LEN(8), .OVERLAP(1), .MEALY(0), .CNT_W(8)) dut2 (
      .clk(clk), .resetn(resetn), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
      .cfg_len(cfg_len), .i_valid(i_valid), .i(i), .y(y_w[2]), .match_cnt(c2), .armed(armed_w[2]));
   seq_detect_param #(.MAX_LEN(8), .OVERLAP(1), .MEALY(1), .CNT_W(2)) dut3 (
      .clk(clk), .resetn(resetn), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
      .cfg_len(cfg_len), .i_valid(i_valid), .i(i), .y(y_w[3]), .match_cnt(c3), .armed(armed_w[3]));

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_hist.delete();
      repeat (8) m_hist.push_back(1'b0);
      m_pat = 0;
      m_len = 0;
      for (int d = 0; d < ND; d++) begin
         m_fill[d] = 0;
         m_cnt[d]  = 0;
         m_yreg[d] = 1'b0;
      end
   endtask

   // the last m_len received bits, including b, must equal the pattern
   function automatic bit model_hit(input int d, input bit v, input bit ld, input bit b);
      bit rx;
      if (!v || ld || m_len < 2 || m_fill[d] < m_len - 1) return 1'b0;
      for (int j = 0; j < m_len; j++) begin
         rx = (j == 0) ? b : m_hist[m_hist.size() - j];
         if (rx != m_pat[j]) return 1'b0;
      end
      return 1'b1;
   endfunction

   task automatic step(input bit rst_n, input bit ld, input logic [7:0] p,
                       input int l, input bit v, input bit b);
      logic [10*ND-1:0] e;
      bit hit[ND];
      bit ye, ae;
      resetn      = rst_n;
      cfg_load    = ld;
      cfg_pattern = p;
      cfg_len     = 4'(l);
      i_valid     = v;
      i           = b;
      for (int d = 0; d < ND; d++) begin
         hit[d] = model_hit(d, v, ld, b);
         ye = (me[d] != 0) ? hit[d] : m_yreg[d];
         ae = (m_len >= 2) && (m_fill[d] + 1 >= m_len);
         e[d*10 +: 10] = {ye, ae, 8'(m_cnt[d])};
      end
      exp_q.push_back(e);
      @(posedge clk);
      if (!rst_n) begin
         model_reset();
      end else if (ld) begin
         m_pat = p;
         m_len = (l > 8) ? 8 : l;
         for (int d = 0; d < ND; d++) begin
            m_fill[d] = 0;
            m_cnt[d]  = 0;
            m_yreg[d] = 1'b0;
         end
      end else begin
         for (int d = 0; d < ND; d++) begin
            m_yreg[d] = hit[d];
            if (hit[d] && m_cnt[d] < cmax[d]) m_cnt[d]++;
            if (v) m_fill[d] = (hit[d] && ov[d] == 0) ? 0 : ((m_fill[d] < 8) ? m_fill[d] + 1 : 8);
         end
         if (v) begin
            m_hist.push_back(b);
            void'(m_hist.pop_front());
         end
      end
      #1;
   endtask

   task automatic do_reset();
      step(1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0);
   endtask

   task automatic load(input logic [7:0] p, input int l);
      step(1'b1, 1'b1, p, l, 1'b0, 1'b0);
   endtask

   task automatic send(input bit b);
      step(1'b1, 1'b0, 8'h00, 0, 1'b1, b);
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b0);
   endtask

   // monitor: every cycle each variant presents y/armed/match_cnt
   always @(negedge clk) begin
      logic [10*ND-1:0] e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         for (int d = 0; d < ND; d++) begin
            chk($sformatf("dut%0d y", d),         int'(y_w[d]),     int'(e[d*10+9]));
            chk($sformatf("dut%0d armed", d),     int'(armed_w[d]), int'(e[d*10+8]));
            chk($sformatf("dut%0d match_cnt", d), int'(cnt_w[d]),   int'(e[d*10 +: 8]));
         end
      end
   end

   initial begin
      logic [7:0] p;
      int l;
      resetn = 1'b0; cfg_load = 1'b0; cfg_pattern = '0; cfg_len = '0; i_valid = 1'b0; i = 1'b0;
      @(posedge clk);
      #1;
      model_reset();
      do_reset();
      do_reset();

      // 101 overlap vs non-overlap
      load(8'b101, 3);
      send(1); send(0); send(1); send(0); send(1);
      chk("ovl 10101 cnt", int'(cnt_w[0]), 2);
      chk("novl 10101 cnt", int'(cnt_w[1]), 1);
      send(0); send(1);
      chk("novl 1010101 cnt", int'(cnt_w[1]), 2);
      chk("ovl 1010101 cnt", int'(cnt_w[0]), 3);

      // Moore 1101 with an idle gap inside the pattern
      load(8'b1101, 4);
      send(1); send(1); idle(2); send(0); send(1);
      idle(1);
      chk("moore 1101 cnt", int'(cnt_w[2]), 1);

      // reset mid-pattern abandons the partial match
      load(8'b101, 3);
      send(1); send(0);
      do_reset();
      load(8'b101, 3);
      send(1);
      chk("post-reset partial cnt", int'(cnt_w[0]), 0);
      send(0); send(1);
      chk("post-reset full cnt", int'(cnt_w[0]), 1);

      // length clamp: 12 -> 8, pattern A5 sent MSB first
      load(8'hA5, 12);
      for (int k = 7; k >= 1; k--) begin
         p = 8'hA5;
         send(p[k]);
      end
      chk("clamp 7 bits cnt", int'(cnt_w[0]), 0);
      send(1'b1);
      chk("clamp 8 bits cnt", int'(cnt_w[0]), 1);

      // length 1 disables detection
      load(8'h01, 1);
      repeat (20) send(1'($urandom_range(0, 1)));
      chk("len1 cnt", int'(cnt_w[0]), 0);

      // 2-bit counter saturation with pattern 11 overlapping
      load(8'b11, 2);
      send(1);
      chk("sat bit1", int'(cnt_w[3]), 0);
      send(1); chk("sat bit2", int'(cnt_w[3]), 1);
      send(1); chk("sat bit3", int'(cnt_w[3]), 2);
      send(1); chk("sat bit4", int'(cnt_w[3]), 3);
      send(1); chk("sat bit5", int'(cnt_w[3]), 3);

      // randomized traffic with occasional reloads (some with i_valid high) and resets
      for (int n = 0; n < 1500; n++) begin
         if ($urandom_range(0, 299) == 0) begin
            do_reset();
         end else if ($urandom_range(0, 99) == 0 || n == 0) begin
            p = 8'($urandom_range(0, 255));
            l = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 12) : $urandom_range(2, 5);
            step(1'b1, 1'b1, p, l, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         end else if ($urandom_range(0, 3) == 0) begin
            idle(1);
         end else begin
            send(1'($urandom_range(0, 1)));
         end
      end

      repeat (2) @(negedge clk);
      chk("scoreboard drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
